// File: rtl/execute_stage.sv
// Execute stage of the bf8b pipeline: ALU ops, data-memory load/store via
// req/ack, and a one-cycle ready/err pulse with registered results to writeback.
module execute_stage #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] op,
  input  logic [3:0] reg_addr,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic       busy,
  output logic       ready,
  output logic       err,
  output logic [3:0] out_op,
  output logic [3:0] out_reg_addr,
  output logic [7:0] out_val,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  localparam logic [3:0] OP_LOD  = 4'b0001;
  localparam logic [3:0] OP_STR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LODI = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;

  // Counter value in the last MEM cycle before abort.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] reg_q, reg_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [3:0] out_op_q, out_op_d;
  logic [3:0] out_reg_q, out_reg_d;
  logic [7:0] out_val_q, out_val_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;

  logic is_mem;
  logic tmo;

  assign is_mem = (op == OP_LOD) || (op == OP_STR);
  assign tmo    = (cnt_q == TMO_LAST);

  function automatic logic [7:0] alu(
    input logic [3:0] o,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] i
  );
    logic [7:0] r;
    r = '0;
    unique case (1'b1)
      (o == OP_ADD):  r = x + y;
      (o == OP_ADDI): r = x + i;
      (o == OP_LODI): r = i;
      (o == OP_NAND): r = ~(x & y);
      default:        r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = is_mem ? MEM : DONE;
      MEM:     if (mem_ack || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    ready = (state_q == DONE);
    err   = err_q;
  end

  always_comb begin
    op_d        = op_q;
    reg_d       = reg_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_op_d    = out_op_q;
    out_reg_d   = out_reg_q;
    out_val_d   = out_val_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          op_d  = op;
          reg_d = reg_addr;
          if (is_mem) begin
            mem_addr_d = b;
            mem_rd_d   = (op == OP_LOD);
            mem_wr_d   = (op == OP_STR);
            if (op == OP_STR) mem_wdata_d = a;
            cnt_d = '0;
          end else begin
            out_op_d  = op;
            out_reg_d = reg_addr;
            out_val_d = alu(op, a, b, imm);
            err_d     = 1'b0;
          end
        end
      end
      MEM: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack || tmo) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          out_op_d  = op_q;
          out_reg_d = reg_q;
          out_val_d = (mem_ack && op_q == OP_LOD) ? mem_rdata : 8'h00;
          err_d     = !mem_ack;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    err_d = 1'b0;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_op_q    <= '0;
      out_reg_q   <= '0;
      out_val_q   <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      op_q        <= op_d;
      reg_q       <= reg_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_op_q    <= out_op_d;
      out_reg_q   <= out_reg_d;
      out_val_q   <= out_val_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign out_op       = out_op_q;
  assign out_reg_addr = out_reg_q;
  assign out_val      = out_val_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: transaction model with a
// per-cycle compare process plus directed literal checks.
module tb_execute_stage;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] op;
  logic [3:0] reg_addr;
  logic [7:0] a, b, imm;
  logic       busy, ready, err;
  logic [3:0] out_op, out_reg_addr;
  logic [7:0] out_val;
  logic [7:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  execute_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op),
    .reg_addr(reg_addr), .a(a), .b(b), .imm(imm),
    .busy(busy), .ready(ready), .err(err),
    .out_op(out_op), .out_reg_addr(out_reg_addr),
    .out_val(out_val), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         en_cyc;
    int         rdy_cyc;
    logic [3:0] op;
    logic [3:0] ra;
    logic [7:0] val;
    logic       err;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_val(
    input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
    input logic [7:0] i, input bit acked, input logic [7:0] rd);
    case (o)
      4'd1:    return acked ? rd : 8'h00;
      4'd3:    return 8'((int'(x) + int'(y)) % 256);
      4'd4:    return 8'((int'(x) + int'(i)) % 256);
      4'd5:    return i;
      4'd6:    return ~(x & y);
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle compare against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_on) begin
        if (q.size() > 0 && cyc > q[0].rdy_cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL ready_missing: got none expected at cycle %0d",
                   q[0].rdy_cyc);
          void'(q.pop_front());
        end
        chk("busy", busy, (q.size() > 0 && cyc > q[0].en_cyc));
        if (ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_unexpected: got ready=1 expected 0");
          end else begin
            chk("ready_cycle", cyc, q[0].rdy_cyc);
            chk("out_op", out_op, q[0].op);
            chk("out_reg_addr", out_reg_addr, q[0].ra);
            chk("out_val", out_val, q[0].val);
            chk("err", err, q[0].err);
            void'(q.pop_front());
          end
        end else begin
          chk("err_idle", err, 1'b0);
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] o, input logic [3:0] ra,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] i, input int ack_after,
                        input logic [7:0] rd, input bit poke);
    bit   is_mem;
    bit   acked;
    int   lat;
    exp_t e;
    is_mem = (o == 4'd1) || (o == 4'd2);
    acked  = is_mem && ack_after >= 1 && ack_after <= TMO;
    lat    = !is_mem ? 1 : (acked ? ack_after + 1 : TMO + 1);
    @(negedge clk);
    en = 1'b1; op = o; reg_addr = ra; a = x; b = y; imm = i;
    e.en_cyc  = cyc;
    e.rdy_cyc = cyc + lat;
    e.op      = o;
    e.ra      = ra;
    e.val     = model_val(o, x, y, i, acked, rd);
    e.err     = is_mem && !acked;
    q.push_back(e);
    @(posedge clk);
    #1 en = 1'b0;
    if (is_mem) begin
      for (int k = 1; k <= TMO; k++) begin
        @(negedge clk);
        chk("mem_rd", mem_rd, (o == 4'd1));
        chk("mem_wr", mem_wr, (o == 4'd2));
        chk("mem_addr", mem_addr, y);
        if (o == 4'd2) chk("mem_wdata", mem_wdata, x);
        if (poke && k == 2) begin
          en = 1'b1;
          op = 4'd3;
        end
        if (k == ack_after) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        en        = 1'b0;
        op        = o;
        if (k == ack_after) break;
      end
      @(negedge clk);
      chk("mem_rd_drop", mem_rd, 1'b0);
      chk("mem_wr_drop", mem_wr, 1'b0);
    end else begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; op = '0; reg_addr = '0;
    a = '0; b = '0; imm = '0; mem_rdata = 8'hEE; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_out_val", out_val, 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    run_op(4'd3, 4'd3, 8'hF0, 8'h20, 8'h00, 0, 8'h00, 0);
    chk("lit_add", out_val, 8'h10);
    chk("lit_add_op", out_op, 4'b0011);
    chk("lit_add_ra", out_reg_addr, 4'd3);
    run_op(4'd6, 4'd1, 8'hCC, 8'hAA, 8'h00, 0, 8'h00, 0);
    chk("lit_nand", out_val, 8'h77);
    run_op(4'd4, 4'd2, 8'h01, 8'h00, 8'hFF, 0, 8'h00, 0);
    chk("lit_addi", out_val, 8'h00);
    run_op(4'd5, 4'd4, 8'h00, 8'h00, 8'h5A, 0, 8'h00, 0);
    chk("lit_lodi", out_val, 8'h5A);
    run_op(4'd15, 4'd9, 8'h12, 8'h34, 8'h56, 0, 8'h00, 0);
    chk("lit_unk_op", out_op, 4'hF);
    chk("lit_unk_val", out_val, 8'h00);

    run_op(4'd1, 4'd5, 8'h00, 8'h40, 8'h00, 3, 8'h9E, 0);
    chk("lit_lod", out_val, 8'h9E);
    run_op(4'd2, 4'd6, 8'h33, 8'h10, 8'h00, 1, 8'h00, 0);
    chk("lit_str_op", out_op, 4'b0010);
    chk("lit_str_val", out_val, 8'h00);

    run_op(4'd1, 4'd7, 8'h00, 8'h55, 8'h00, 0, 8'h00, 0);
    chk("lit_tmo_val", out_val, 8'h00);
    run_op(4'd1, 4'd8, 8'h00, 8'h66, 8'h00, 15, 8'hC3, 0);
    chk("lit_ack15", out_val, 8'hC3);
    run_op(4'd1, 4'd2, 8'h00, 8'h77, 8'h00, 4, 8'hA5, 1);
    chk("lit_poke", out_val, 8'hA5);

    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_val", out_val, 8'hA5);

    chk_on = 1'b0;
    q.delete();
    @(negedge clk);
    en = 1'b1; op = 4'd1; b = 8'h44;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_mem_rd", mem_rd, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_rd", mem_rd, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", ready, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    chk("rst_mid_out_val", out_val, 8'h00);
    chk("rst_mid_out_op", out_op, 4'h0);
    chk("rst_mid_mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk_on = 1'b1;

    run_op(4'd3, 4'd1, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 0);
    chk("lit_wrap", out_val, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
